// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: runs loads and stores through a request/response
// handshake and drives the decode-stage register-file write port.
module mem_writeback_stage #(
  parameter int XLEN          = 64,
  parameter int REGISTER_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rf_write_enable,
  input  logic [REGISTER_SIZE-1:0] rf_write_addr,
  input  logic [1:0]               rf_write_data_sel,
  input  logic                     dm_read_enable,
  input  logic                     dm_write_enable,
  input  logic [2:0]               dm_load_type,
  input  logic [XLEN-1:0]          alu_result,
  input  logic [XLEN-1:0]          dm_write_data,
  input  logic [XLEN-1:0]          pc_plus4,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [XLEN-1:0]          mem_req_addr,
  output logic [XLEN-1:0]          mem_req_wdata,
  output logic [1:0]               mem_req_size,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  output logic                     rf_writeback_enable,
  output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
  output logic [XLEN-1:0]          rf_writeback_data,
  output logic [XLEN-1:0]          dm_data_bypass,
  output logic                     stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Byte offset within the doubleword, low bits cleared to the access size.
  function automatic logic [2:0] mask_offset(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] off;
    case (size)
      2'd0:    off = addr_lo;
      2'd1:    off = {addr_lo[2:1], 1'b0};
      2'd2:    off = {addr_lo[2], 2'b00};
      default: off = 3'b000;
    endcase
    return off;
  endfunction

  // Pull the addressed field out of the response doubleword and extend it.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] data,
                                                   input logic [2:0] addr_lo,
                                                   input logic [2:0] ltype);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = data >> {mask_offset(addr_lo, ltype[1:0]), 3'b000};
    case (ltype)
      3'b000:  res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b100:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  res = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Writeback source select; the "no write" encoding yields zero.
  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] load, input logic [XLEN-1:0] link);
    logic [XLEN-1:0] res;
    case (sel)
      2'b00:   res = alu;
      2'b01:   res = load;
      2'b10:   res = link;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  state_t                     state_r, state_next_s;
  logic                       in_ready_r, req_valid_r, req_we_r;
  logic [XLEN-1:0]            req_addr_r, req_wdata_r, pc4_r;
  logic [1:0]                 req_size_r, sel_r;
  logic [2:0]                 load_type_r;
  logic                       cap_en_r;
  logic [REGISTER_SIZE-1:0]   rd_r;
  logic                       wb_en_r, wb_en_next_s;
  logic [REGISTER_SIZE-1:0]   wb_addr_r, wb_addr_next_s;
  logic [XLEN-1:0]            wb_data_r, wb_data_next_s;
  logic                       accept_s, is_mem_s, en_in_s;

  assign accept_s = in_valid & in_ready_r;
  assign is_mem_s = dm_read_enable | dm_write_enable;
  assign en_in_s  = rf_write_enable & (rf_write_data_sel != 2'b11) &
                    (rf_write_addr != {REGISTER_SIZE{1'b0}});

  // Next-state logic for the IDLE/REQ/WAIT handshake sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mem_s) state_next_s = ST_REQ;
        else                      state_next_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_req_ready) state_next_s = req_we_r ? ST_IDLE : ST_WAIT;
        else               state_next_s = ST_REQ;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) state_next_s = ST_IDLE;
        else               state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Writeback strobe/address/data; address and data hold when no write occurs.
  always_comb begin
    wb_en_next_s   = 1'b0;
    wb_addr_next_s = wb_addr_r;
    wb_data_next_s = wb_data_r;
    if ((state_r == ST_IDLE) && accept_s && !is_mem_s) begin
      wb_en_next_s = en_in_s;
      if (en_in_s) begin
        wb_addr_next_s = rf_write_addr;
        wb_data_next_s = wb_mux(rf_write_data_sel, alu_result, {XLEN{1'b0}}, pc_plus4);
      end else begin
        wb_addr_next_s = wb_addr_r;
        wb_data_next_s = wb_data_r;
      end
    end else if ((state_r == ST_WAIT) && mem_rsp_valid) begin
      wb_en_next_s = cap_en_r;
      if (cap_en_r) begin
        wb_addr_next_s = rd_r;
        wb_data_next_s = wb_mux(sel_r, req_addr_r,
                                load_extract(mem_rsp_data, req_addr_r[2:0], load_type_r), pc4_r);
      end else begin
        wb_addr_next_s = wb_addr_r;
        wb_data_next_s = wb_data_r;
      end
    end else begin
      wb_en_next_s = 1'b0;
    end
  end

  // State, handshake flags and writeback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      req_valid_r <= 1'b0;
      wb_en_r     <= 1'b0;
      wb_addr_r   <= {REGISTER_SIZE{1'b0}};
      wb_data_r   <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      req_valid_r <= (state_next_s == ST_REQ);
      wb_en_r     <= wb_en_next_s;
      wb_addr_r   <= wb_addr_next_s;
      wb_data_r   <= wb_data_next_s;
    end
  end

  // Capture the instruction fields when it is accepted; they stay stable through REQ/WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= {XLEN{1'b0}};
      req_wdata_r <= {XLEN{1'b0}};
      req_size_r  <= 2'd0;
      load_type_r <= 3'd0;
      cap_en_r    <= 1'b0;
      rd_r        <= {REGISTER_SIZE{1'b0}};
      sel_r       <= 2'd0;
      pc4_r       <= {XLEN{1'b0}};
    end else if (accept_s) begin
      req_we_r    <= dm_write_enable & ~dm_read_enable;
      req_addr_r  <= alu_result;
      req_wdata_r <= dm_write_data << {mask_offset(alu_result[2:0], dm_load_type[1:0]), 3'b000};
      req_size_r  <= dm_load_type[1:0];
      load_type_r <= dm_load_type;
      cap_en_r    <= en_in_s;
      rd_r        <= rf_write_addr;
      sel_r       <= rf_write_data_sel;
      pc4_r       <= pc_plus4;
    end
  end

  assign in_ready            = in_ready_r;
  assign stall               = ~in_ready_r;
  assign mem_req_valid       = req_valid_r;
  assign mem_req_we          = req_we_r;
  assign mem_req_addr        = req_addr_r;
  assign mem_req_wdata       = req_wdata_r;
  assign mem_req_size        = req_size_r;
  assign rf_writeback_enable = wb_en_r;
  assign rf_writeback_addr   = wb_addr_r;
  assign rf_writeback_data   = wb_data_r;
  assign dm_data_bypass      = wb_data_r;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed self-checking bench for mem_writeback_stage.
module tb_mem_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [1:0]  rf_write_data_sel;
  logic        dm_read_enable, dm_write_enable;
  logic [2:0]  dm_load_type;
  logic [63:0] alu_result, dm_write_data, pc_plus4;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [1:0]  mem_req_size;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        rf_writeback_enable;
  logic [4:0]  rf_writeback_addr;
  logic [63:0] rf_writeback_data, dm_data_bypass;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  mem_writeback_stage #(.XLEN(64), .REGISTER_SIZE(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data_sel(rf_write_data_sel), .dm_read_enable(dm_read_enable),
    .dm_write_enable(dm_write_enable), .dm_load_type(dm_load_type),
    .alu_result(alu_result), .dm_write_data(dm_write_data), .pc_plus4(pc_plus4),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_writeback_enable(rf_writeback_enable), .rf_writeback_addr(rf_writeback_addr),
    .rf_writeback_data(rf_writeback_data), .dm_data_bypass(dm_data_bypass), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; rf_write_enable = 1'b0; rf_write_addr = 5'd0;
    rf_write_data_sel = 2'b00; dm_read_enable = 1'b0; dm_write_enable = 1'b0;
    dm_load_type = 3'b000; alu_result = 64'd0; dm_write_data = 64'd0; pc_plus4 = 64'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'd0;
    #1;
    n_checks++;
    if ({in_ready, stall, mem_req_valid, mem_req_we, rf_writeback_enable} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 10000",
               {in_ready, stall, mem_req_valid, mem_req_we, rf_writeback_enable});
    end
    n_checks++;
    if ({mem_req_addr, mem_req_wdata, rf_writeback_data, dm_data_bypass} !== 256'd0 ||
        rf_writeback_addr !== 5'd0 || mem_req_size !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h wbdata=%h wbaddr=%0d",
               mem_req_addr, mem_req_wdata, rf_writeback_data, rf_writeback_addr);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_op();
    in_valid = 1'b1; rf_write_enable = 1'b1; rf_write_addr = 5'd5;
    rf_write_data_sel = 2'b00; alu_result = 64'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (rf_writeback_enable !== 1'b1 || rf_writeback_addr !== 5'd5 ||
        rf_writeback_data !== 64'h1234 || dm_data_bypass !== 64'h1234) begin
      n_fail++;
      $display("FAIL alu_op: en=%b addr=%0d data=%h byp=%h want 1/5/1234/1234",
               rf_writeback_enable, rf_writeback_addr, rf_writeback_data, dm_data_bypass);
    end
    @(negedge clk);
    n_checks++;
    if (rf_writeback_enable !== 1'b0 || rf_writeback_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL alu_single_strobe: en=%b addr=%0d want 0/5", rf_writeback_enable, rf_writeback_addr);
    end
  endtask

  task automatic test_link_op();
    in_valid = 1'b1; rf_write_enable = 1'b1; rf_write_addr = 5'd1;
    rf_write_data_sel = 2'b10; alu_result = 64'h9999; pc_plus4 = 64'h0000_0000_0040_0008;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (rf_writeback_enable !== 1'b1 || rf_writeback_addr !== 5'd1 ||
        rf_writeback_data !== 64'h0000_0000_0040_0008) begin
      n_fail++;
      $display("FAIL link_op: en=%b addr=%0d data=%h want 1/1/400008",
               rf_writeback_enable, rf_writeback_addr, rf_writeback_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    rf_write_enable = 1'b1; rf_write_data_sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rf_write_addr = 5'(i + 1); alu_result = vals[i];
      @(negedge clk);
      n_checks++;
      if (rf_writeback_enable !== 1'b1 || rf_writeback_addr !== 5'(i + 1) ||
          rf_writeback_data !== vals[i] || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: en=%b addr=%0d data=%h rdy=%b want 1/%0d/%h/1",
                 i, rf_writeback_enable, rf_writeback_addr, rf_writeback_data, in_ready, i + 1, vals[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rf_writeback_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_end: en=%b want 0", rf_writeback_enable);
    end
  endtask

  task automatic test_no_write();
    in_valid = 1'b1; rf_write_enable = 1'b1; rf_write_addr = 5'd0;
    rf_write_data_sel = 2'b00; alu_result = 64'h5555;
    @(negedge clk);
    n_checks++;
    if (rf_writeback_enable !== 1'b0 || rf_writeback_addr !== 5'd3 || rf_writeback_data !== 64'h33) begin
      n_fail++;
      $display("FAIL x0_write: en=%b addr=%0d data=%h want 0/3/33",
               rf_writeback_enable, rf_writeback_addr, rf_writeback_data);
    end
    rf_write_addr = 5'd7; rf_write_data_sel = 2'b11; alu_result = 64'h7777;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (rf_writeback_enable !== 1'b0 || rf_writeback_addr !== 5'd3 || rf_writeback_data !== 64'h33) begin
      n_fail++;
      $display("FAIL sel11_write: en=%b addr=%0d data=%h want 0/3/33",
               rf_writeback_enable, rf_writeback_addr, rf_writeback_data);
    end
  endtask

  task automatic test_load(input string name, input logic [63:0] addr, input logic [2:0] ltype,
                           input logic [63:0] rsp, input logic [63:0] exp, input logic [4:0] rd,
                           input logic also_store, input int req_wait);
    in_valid = 1'b1; dm_read_enable = 1'b1; dm_write_enable = also_store;
    rf_write_enable = 1'b1; rf_write_addr = rd; rf_write_data_sel = 2'b01;
    alu_result = addr; dm_load_type = ltype; dm_write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_req_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; dm_read_enable = 1'b0; dm_write_enable = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== addr ||
        mem_req_size !== ltype[1:0] || stall !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_req: v=%b we=%b addr=%h size=%0d stall=%b want 1/0/%h/%0d/1",
               name, mem_req_valid, mem_req_we, mem_req_addr, mem_req_size, stall, addr, ltype[1:0]);
    end
    for (int i = 0; i < req_wait; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== addr || rf_writeback_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_req_hold[%0d]: v=%b addr=%h wb=%b want 1/%h/0",
                 name, i, mem_req_valid, mem_req_addr, rf_writeback_enable, addr);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0 || rf_writeback_enable !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait: v=%b wb=%b stall=%b want 0/0/1", name, mem_req_valid, rf_writeback_enable, stall);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    n_checks++;
    if (rf_writeback_enable !== 1'b1 || rf_writeback_addr !== rd || rf_writeback_data !== exp ||
        dm_data_bypass !== exp || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_data: en=%b addr=%0d data=%h rdy=%b want 1/%0d/%h/1",
               name, rf_writeback_enable, rf_writeback_addr, rf_writeback_data, in_ready, rd, exp);
    end
    @(negedge clk);
    n_checks++;
    if (rf_writeback_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_single_strobe: en=%b want 0", name, rf_writeback_enable);
    end
  endtask

  task automatic test_store();
    in_valid = 1'b1; dm_write_enable = 1'b1; rf_write_enable = 1'b0; rf_write_addr = 5'd0;
    rf_write_data_sel = 2'b11; alu_result = 64'h1002; dm_write_data = 64'hAB; dm_load_type = 3'b000;
    mem_req_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; dm_write_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 64'h1002 ||
          mem_req_wdata[23:16] !== 8'hAB || mem_req_size !== 2'd0 || stall !== 1'b1 ||
          rf_writeback_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL store_hold[%0d]: v=%b we=%b addr=%h wdata=%h size=%0d stall=%b wb=%b",
                 i, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size, stall,
                 rf_writeback_enable);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b1 || rf_writeback_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL store_done: v=%b stall=%b rdy=%b wb=%b want 0/0/1/0",
               mem_req_valid, stall, in_ready, rf_writeback_enable);
    end
  endtask

  task automatic test_reset_mid_op();
    in_valid = 1'b1; dm_read_enable = 1'b1; rf_write_enable = 1'b1; rf_write_addr = 5'd9;
    rf_write_data_sel = 2'b01; alu_result = 64'h1000; dm_load_type = 3'b011;
    mem_req_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; dm_read_enable = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, stall, mem_req_valid, rf_writeback_enable} !== 4'b1000 ||
        rf_writeback_data !== 64'd0 || mem_req_addr !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: rdy=%b stall=%b v=%b wb=%b data=%h addr=%h want 1/0/0/0/0/0",
               in_ready, stall, mem_req_valid, rf_writeback_enable, rf_writeback_data, mem_req_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    n_checks++;
    if (rf_writeback_enable !== 1'b0 || in_ready !== 1'b1 || rf_writeback_data !== 64'd0) begin
      n_fail++;
      $display("FAIL late_rsp: wb=%b rdy=%b data=%h want 0/1/0", rf_writeback_enable, in_ready, rf_writeback_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_link_op();
    test_back_to_back();
    test_no_write();
    test_load("lb",  64'h1003, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 5'd10, 1'b0, 0);
    test_load("lbu", 64'h1003, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 5'd11, 1'b1, 0);
    test_load("lhu", 64'h1006, 3'b101, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 5'd12, 1'b0, 1);
    test_load("lw",  64'h1004, 3'b010, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 5'd13, 1'b0, 2);
    test_load("ld",  64'h1008, 3'b011, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9, 5'd14, 1'b0, 0);
    test_store();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
